// File: rtl/iq_capture_sched.sv
// Capture-and-replay IQ scheduler: packs one bit per I/Q byte into a buffer, then replays it once per Doppler pass.
// Optional build macro IQCAP_DROP_CNT_EN adds the drop_cnt discard counter.
module iq_capture_sched #(
  parameter int SAMPLE_BIT = 2,
  parameter int PACK_W     = 16,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       len,
  input  logic [7:0]        passes,
  input  logic              in_valid,
  input  logic [7:0]        in_i,
  input  logic [7:0]        in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PACK_W-1:0] out_i,
  output logic [PACK_W-1:0] out_q,
  output logic              out_last,
  output logic [7:0]        pass_idx,
  output logic              busy,
  output logic              done
`ifdef IQCAP_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CAP = 2'd1, S_READ = 2'd2, S_DONE = 2'd3;
  localparam int SW = (PACK_W > 1) ? $clog2(PACK_W) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  typedef struct packed {
    logic [PACK_W-1:0] i;
    logic [PACK_W-1:0] q;
    logic              last;
    logic [7:0]        pidx;
  } ent_t;

  logic [1:0]          state;
  logic [AW:0]         len_r, len_m1;
  logic [7:0]          pass_last, rpass, rd_pidx;
  logic [AW-1:0]       wcnt, raddr;
  logic [SW-1:0]       scnt;
  logic [PACK_W-1:0]   pk_i, pk_q, new_i, new_q, rd_di, rd_dq;
  logic [2*PACK_W-1:0] mem [DEPTH];
  logic                rd_vld, rd_last, rd_all;
  ent_t                ent0, ent1, rd_ent;
  logic [1:0]          cnt;
  logic [2:0]          occ;
  logic                start_ok, cap_fire, word_done, cap_end, pop, issue, rd_end, fin;
  logic                unused_ok;

  assign unused_ok = ^{in_i, in_q};
  assign len_m1    = len_r - ONE_L;
  assign start_ok  = (state == S_IDLE) && start && !abort && (len != '0) && (len <= DEPTH_L);
  assign cap_fire  = (state == S_CAP) && in_valid;
  assign word_done = cap_fire && (scnt == SW'(PACK_W-1));
  assign cap_end   = word_done && ({1'b0, wcnt} == len_m1);
  // Sample k lands at bit k: shift in from the top so the first sample ends at bit 0.
  assign new_i     = {in_i[SAMPLE_BIT], pk_i[PACK_W-1:1]};
  assign new_q     = {in_q[SAMPLE_BIT], pk_q[PACK_W-1:1]};

  assign out_valid = (cnt != 2'd0);
  assign out_i     = ent0.i;
  assign out_q     = ent0.q;
  assign out_last  = ent0.last;
  assign pass_idx  = ent0.pidx;
  assign busy      = (state != S_IDLE);
  assign pop       = out_valid && out_ready;

  // Reads in flight plus skid entries never exceed two, so the skid cannot overflow.
  assign occ    = {1'b0, cnt} + {2'b0, rd_vld} - {2'b0, pop};
  assign issue  = (state == S_READ) && !rd_all && (occ <= 3'd1);
  assign rd_end = ({1'b0, raddr} == len_m1);
  assign fin    = pop && ent0.last && (ent0.pidx == pass_last);
  assign rd_ent = {rd_di, rd_dq, rd_last, rd_pidx};

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state  <= S_IDLE;
      scnt   <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_all <= 1'b0;
      ent0   <= '0;
      ent1   <= '0;
      done   <= 1'b0;
    end else begin
      done   <= fin;
      rd_vld <= issue;
      case (state)
        S_IDLE:  if (start_ok) state <= S_CAP;
        S_CAP:   if (cap_end)  state <= S_READ;
        S_READ:  if (fin)      state <= S_DONE;
        default: state <= S_IDLE;
      endcase
      if (start_ok) begin
        scnt   <= '0;
        rd_all <= 1'b0;
      end
      if (cap_fire) scnt <= word_done ? '0 : scnt + SW'(1);
      if (issue && rd_end && (rpass == pass_last)) rd_all <= 1'b1;
      if (rd_vld && (cnt == 2'd0 || (pop && cnt == 2'd1))) ent0 <= rd_ent;
      else if (pop && cnt == 2'd2)                          ent0 <= ent1;
      if (rd_vld && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) ent1 <= rd_ent;
      cnt <= cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      len_r     <= len;
      pass_last <= (passes == 8'd0) ? 8'd0 : passes - 8'd1;
      wcnt      <= '0;
      raddr     <= '0;
      rpass     <= '0;
    end
    if (cap_fire) begin
      pk_i <= new_i;
      pk_q <= new_q;
    end
    if (word_done) begin
      mem[wcnt] <= {new_i, new_q};
      wcnt      <= wcnt + AW'(1);
    end
    if (issue) begin
      {rd_di, rd_dq} <= mem[raddr];
      rd_last        <= rd_end;
      rd_pidx        <= rpass;
      if (rd_end) begin
        raddr <= '0;
        rpass <= rpass + 8'd1;
      end else begin
        raddr <= raddr + AW'(1);
      end
    end
  end

`ifdef IQCAP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      drop_cnt <= '0;
    else if (in_valid && (state == S_READ || state == S_DONE) && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/iq_capture_sched.md
# iq_capture_sched

Capture-and-replay scheduler between the 4 MHz IQ byte stream and the acquisition correlator. On `start`, it takes one bit (`SAMPLE_BIT`) from each signed 8-bit I and Q byte and packs those bits into words. It stores `len` words in an internal sample buffer, then replays the buffer `passes` times to the correlator over a valid/ready stream, one pass per Doppler bin. This lets one snapshot be reused across the whole Doppler search without re-capturing.

## Interface
- `SAMPLE_BIT`, 2: bit index taken from each input byte.
- `PACK_W`, 16: samples packed per buffer word (per channel).
- `DEPTH`, 256: buffer depth in words.
- `AW`, 8: address width; `2**AW == DEPTH`.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin capture; honoured only in IDLE.
- `abort`, in, 1: return to IDLE next cycle from any state.
- `len`, in, AW+1: words to capture, 1..DEPTH; sampled on accepted `start`.
- `passes`, in, 8: replay count; 0 is treated as 1; sampled on accepted `start`.
- `in_valid`, in, 1: input byte pair valid.
- `in_i`, in, 8: signed I byte.
- `in_q`, in, 8: signed Q byte.
- `out_valid`, out, 1: replay word valid.
- `out_ready`, in, 1: correlator accepts word.
- `out_i`, out, PACK_W: packed I bits.
- `out_q`, out, PACK_W: packed Q bits.
- `out_last`, out, 1: final word of the current pass.
- `pass_idx`, out, 8: index of the current pass, 0-based.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the final word of the final pass is accepted.
- `drop_cnt`, out, 16: present only with `IQCAP_DROP_CNT_EN`.

## Operation
- States: IDLE, CAPTURE, READOUT, DONE.
- IDLE → CAPTURE on `start` when `1 <= len <= DEPTH`. Otherwise `start` is ignored.
- `start` in any state other than IDLE is ignored.
- CAPTURE:
  - Each `in_valid` cycle shifts `in_i[SAMPLE_BIT]` and `in_q[SAMPLE_BIT]` into the packing registers.
  - The first sample of a word lands at bit 0, sample k at bit k.
  - After PACK_W samples the word is written at the write address, which then increments.
  - After word `len-1` is written: → READOUT.
  - Total samples consumed: `len*PACK_W`. `in_valid` samples beyond that, or arriving outside CAPTURE, are discarded.
- READOUT:
  - Words 0..`len-1` stream in order.
  - `out_last` is high with word `len-1`.
  - After that word is accepted, `pass_idx` increments and the read address wraps to 0.
  - After the final pass's last word is accepted: → DONE.
- DONE: `done`=1 for one cycle, then → IDLE. The buffer retains its contents.
- `abort` in any state:
  - Next cycle: state is IDLE; `out_valid`, `out_last`, `busy` are 0; `pass_idx` is 0.
  - Any partial packing word is discarded.
- `abort` and `start` in the same cycle: `abort` wins and `start` is ignored.
- Reset values: `out_valid`=0, `out_i`=0, `out_q`=0, `out_last`=0, `pass_idx`=0, `busy`=0, `done`=0, `drop_cnt`=0, state IDLE.

## Timing
- `start` accepted at edge N: `busy`=1 after N, and `in_valid` is sampled from edge N+1 onward.
- The buffer has a one-cycle registered read. Replay uses a two-entry output skid.
  - The first `out_valid` rises exactly 2 cycles after entering READOUT.
  - With `out_ready` held at 1, the block sustains one word per cycle, including across pass boundaries (no bubble).
- While `out_valid && !out_ready`, `out_i`, `out_q`, `out_last` and `pass_idx` hold stable.
- `out_valid` never drops without a handshake, except on `abort`/`rst`.
- `done` asserts the cycle after the final handshake. `busy` falls the following cycle.

## Configuration
- `IQCAP_DROP_CNT_EN` defined:
  - `drop_cnt` counts `in_valid` cycles that are discarded while `busy`=1 (READOUT, DONE, or post-capture).
  - The count saturates at 0xFFFF and clears on `rst` or on an accepted `start`.
- Undefined: the port and counter are absent, and discards are silent.

## Test plan
- PACK_W=16, `len`=2, `passes`=1, `in_i` alternating 0x04,0x00, `in_q`=0xFC constant:
  - expect two words `out_i`=0x5555, `out_q`=0xFFFF;
  - `out_last` on the 2nd word;
  - `done` one cycle after its handshake.
- `len`=4, `passes`=3, `out_ready`=1:
  - 12 consecutive valid cycles, no bubble;
  - `pass_idx` 0,0,0,0,1,…,2;
  - `out_last` on cycles 4, 8, 12.
- Random `out_ready` (50%) during READOUT: the word sequence is identical to the `ready`=1 run, and data stays stable while stalled.
- `abort` mid-CAPTURE after 7 samples, then `start` with `len`=1:
  - the first word contains only post-restart samples;
  - `busy` drops for exactly the cycle after `abort`.
- `start` with `len`=0 or `len`=257: no state change, `busy` stays 0. `start` during READOUT: no effect.
- With `IQCAP_DROP_CNT_EN`: 5 `in_valid` cycles during READOUT → `drop_cnt`=5. A new `start` clears it to 0.
